ad9280_receiver: RTL and testbench



---
 rtl/ad9280_receiver.sv | 213 +++++++++++++++++++++
 tb/tb_ad9280_receiver.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9280_receiver.sv
// AD9280 capture engine: samples sample_len bytes, packs them little-endian into 32-bit AXIS words.
// Optional macro ADC_TEST_PATTERN_EN replaces adc_data with an internal 8-bit ramp.
module ad9280_receiver #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        adc_clk,
    input  logic        adc_rst_n,
    input  logic [7:0]  adc_data,
    input  logic        sample_start,
    input  logic [31:0] sample_len,
    output logic        st_clr,
    output logic        busy,
    output logic        overflow,
    output logic [31:0] DMA_AXIS_tdata,
    output logic [3:0]  DMA_AXIS_tkeep,
    output logic        DMA_AXIS_tlast,
    output logic        DMA_AXIS_tvalid,
    input  logic        DMA_AXIS_tready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = 37;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
    state_t state;

    logic          start_d0, start_d1, start_d2, start_d3;
    logic [31:0]   len_d0, len_d1, len_d2;
    logic [31:0]   len_q, cnt;
    logic [23:0]   pack;
    logic [WW-1:0] word_p1, pend_word;
    logic          vld_p1, pend;
    logic [7:0]    sample;
    logic [1:0]    lane;
    logic          start_rise, accept, capturing, last_sample, word_done;

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, space, word_push, pend_push, wr_en;
    logic [WW-1:0] wr_word, head;

    // Word layout is {last, keep[3:0], data[31:0]}; bytes above the filled lane stay zero.
    function automatic logic [WW-1:0] pack_word(input logic [23:0] p, input logic [7:0] s,
                                                 input logic [1:0] ln, input logic last);
        logic [31:0] d;
        logic [3:0]  k;
        d = {8'h00, p};
        case (ln)
            2'd0:    begin d[7:0]   = s; k = 4'b0001; end
            2'd1:    begin d[15:8]  = s; k = 4'b0011; end
            2'd2:    begin d[23:16] = s; k = 4'b0111; end
            default: begin d[31:24] = s; k = 4'b1111; end
        endcase
        return {last, k, d};
    endfunction

    assign start_rise  = start_d2 & ~start_d3;
    assign accept      = (state == IDLE) && start_rise && (len_d2 != 32'd0);
    assign capturing   = (state == CAPTURE) && (cnt != len_q);
    assign lane        = cnt[1:0];
    assign last_sample = (cnt == len_q - 32'd1);
    assign word_done   = (lane == 2'd3) || last_sample;

`ifdef ADC_TEST_PATTERN_EN
    logic [7:0] ramp;
    logic       unused_adc_data;
    assign unused_adc_data = ^adc_data;
    always_ff @(posedge adc_clk) begin
        if (accept)
            ramp <= 8'd0;
        else if (capturing)
            ramp <= ramp + 8'd1;
    end
    assign sample = ramp;
`else
    assign sample = adc_data;
`endif

    // Synchronizers for the quasi-static register-file inputs
    always_ff @(posedge adc_clk) begin
        if (!adc_rst_n) begin
            start_d0 <= 1'b0;
            start_d1 <= 1'b0;
            start_d2 <= 1'b0;
            start_d3 <= 1'b0;
        end else begin
            start_d0 <= sample_start;
            start_d1 <= start_d0;
            start_d2 <= start_d1;
            start_d3 <= start_d2;
        end
    end

    always_ff @(posedge adc_clk) begin
        len_d0 <= sample_len;
        len_d1 <= len_d0;
        len_d2 <= len_d1;
    end

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = DMA_AXIS_tvalid & DMA_AXIS_tready;
    assign space     = ~full | pop;
    assign word_push = vld_p1 & space;
    assign pend_push = pend & ~vld_p1 & space;
    assign wr_en     = word_push | pend_push;
    assign wr_word   = vld_p1 ? word_p1 : pend_word;

    always_ff @(posedge adc_clk) begin
        if (!adc_rst_n) begin
            state    <= IDLE;
            st_clr   <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            vld_p1   <= 1'b0;
            pend     <= 1'b0;
            cnt      <= 32'd0;
        end else begin
            st_clr <= 1'b0;
            vld_p1 <= 1'b0;
            if (vld_p1 && !space) begin
                if (word_p1[WW-1])
                    pend <= 1'b1;
                else
                    overflow <= 1'b1;
            end
            if (pend_push)
                pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        st_clr <= 1'b1;
                        if (len_d2 != 32'd0) begin
                            cnt      <= 32'd0;
                            overflow <= 1'b0;
                            busy     <= 1'b1;
                            state    <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (cnt == len_q) begin
                        state <= DRAIN;
                    end else begin
                        cnt    <= cnt + 32'd1;
                        vld_p1 <= word_done;
                    end
                end
                DRAIN: begin
                    if (!pend && count == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk) begin
        if (accept) begin
            len_q <= len_d2;
            pack  <= 24'd0;
        end else if (capturing) begin
            if (word_done) begin
                word_p1 <= pack_word(pack, sample, lane, last_sample);
                pack    <= 24'd0;
            end else begin
                case (lane)
                    2'd0:    pack[7:0]   <= sample;
                    2'd1:    pack[15:8]  <= sample;
                    default: pack[23:16] <= sample;
                endcase
            end
        end
        if (vld_p1 && !space && word_p1[WW-1])
            pend_word <= word_p1;
    end

    // First-word fall-through word FIFO
    always_ff @(posedge adc_clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge adc_clk) begin
        if (!adc_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        DMA_AXIS_tvalid = (count != '0);
        DMA_AXIS_tdata  = 32'd0;
        DMA_AXIS_tkeep  = 4'd0;
        DMA_AXIS_tlast  = 1'b0;
        if (DMA_AXIS_tvalid) begin
            DMA_AXIS_tdata = head[31:0];
            DMA_AXIS_tkeep = head[35:32];
            DMA_AXIS_tlast = head[36];
        end
    end

endmodule

// File: tb/tb_ad9280_receiver.sv
// Randomized bench for ad9280_receiver: a queue-based behavioural model predicts every output each cycle.
module tb_ad9280_receiver;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  adc_data = 8'd0;
    logic        sample_start = 1'b0;
    logic [31:0] sample_len = 32'd0;
    logic        tready = 1'b0;
    logic        st_clr, busy, overflow, tvalid, tlast;
    logic [31:0] tdata;
    logic [3:0]  tkeep;

    always #5 clk = ~clk;

    ad9280_receiver #(.FIFO_DEPTH(DEPTH)) dut (
        .adc_clk(clk), .adc_rst_n(rst_n), .adc_data(adc_data),
        .sample_start(sample_start), .sample_len(sample_len),
        .st_clr(st_clr), .busy(busy), .overflow(overflow),
        .DMA_AXIS_tdata(tdata), .DMA_AXIS_tkeep(tkeep), .DMA_AXIS_tlast(tlast),
        .DMA_AXIS_tvalid(tvalid), .DMA_AXIS_tready(tready)
    );

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

`ifdef ADC_TEST_PATTERN_EN
    localparam logic [7:0] LEN1_BYTE = 8'h00;
`else
    localparam logic [7:0] LEN1_BYTE = 8'hA5;
`endif

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int n_stclr = 0;
    int start_edge = -1, start_len = 0, e0_ref = 0;
    int tmode = 0;   // 0: ready, 1: stalled, 2: toggle, 3: random
    int dmode = 0;   // 0: random data, 1: ramp, 2: constant 0xA5

    beat_t mq[$];
    beat_t dut_beats[$];
    bit    m_busy, m_stclr, m_ovf, m_pend, m_cap, m_wv, m_last_popped, m_rst_seen;
    beat_t m_pend_w, m_w;
    int    m_k, m_len;
    logic [7:0] m_bytes [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one update per clock edge from pre-edge inputs
    always @(posedge clk) begin : model_p
        logic [7:0] smp;
        int lane;
        bit busy_pre;
        cyc++;
        if (!rst_n) begin
            mq.delete();
            m_busy = 0; m_stclr = 0; m_ovf = 0; m_pend = 0; m_cap = 0; m_wv = 0;
            m_last_popped = 0; m_rst_seen = 1;
        end else begin
            m_rst_seen = 0;
            m_stclr = 0;
            busy_pre = m_busy;
            if (m_last_popped) begin
                m_busy = 0;
                m_last_popped = 0;
            end
            if (mq.size() > 0 && tready) begin
                if (mq[0].last) m_last_popped = 1;
                void'(mq.pop_front());
            end
            if (m_pend && mq.size() < DEPTH) begin
                mq.push_back(m_pend_w);
                m_pend = 0;
            end
            if (m_wv) begin
                m_wv = 0;
                if (mq.size() < DEPTH) mq.push_back(m_w);
                else if (m_w.last) begin m_pend = 1; m_pend_w = m_w; end
                else m_ovf = 1;
            end
            if (m_cap) begin
`ifdef ADC_TEST_PATTERN_EN
                smp = m_k[7:0];
`else
                smp = adc_data;
`endif
                lane = m_k % 4;
                m_bytes[lane] = smp;
                if (lane == 3 || m_k == m_len - 1) begin
                    m_w.data = 32'd0;
                    for (int b = 0; b <= lane; b++) m_w.data[b*8 +: 8] = m_bytes[b];
                    m_w.keep = 4'((1 << (lane + 1)) - 1);
                    m_w.last = (m_k == m_len - 1);
                    m_wv = 1;
                end
                m_k++;
                if (m_k == m_len) m_cap = 0;
            end
            if (cyc == start_edge && !busy_pre) begin
                m_stclr = 1;
                if (start_len != 0) begin
                    m_busy = 1; m_ovf = 0; m_cap = 1; m_k = 0; m_len = start_len;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("st_clr", 64'(st_clr), 64'(m_stclr));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("tvalid", 64'(tvalid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                check("tdata", 64'(tdata), 64'(mq[0].data));
                check("tkeep", 64'(tkeep), 64'(mq[0].keep));
                check("tlast", 64'(tlast), 64'(mq[0].last));
            end else if (m_rst_seen) begin
                check("rst_tdata", 64'(tdata), 64'd0);
                check("rst_tkeep", 64'(tkeep), 64'd0);
                check("rst_tlast", 64'(tlast), 64'd0);
            end
            if (tvalid && tready) dut_beats.push_back({tlast, tkeep, tdata});
            if (st_clr) n_stclr++;
        end
    end

    always @(posedge clk) begin
        #1;
        case (dmode)
            1:       adc_data = 8'(cyc - e0_ref);
            2:       adc_data = 8'hA5;
            default: adc_data = 8'($urandom);
        endcase
        case (tmode)
            0:       tready = 1'b1;
            1:       tready = 1'b0;
            2:       tready = ~tready;
            default: tready = 1'($urandom);
        endcase
    end

    task automatic start_pulse(input int len);
        sample_len = len;
        repeat (5) @(posedge clk);
        #1;
        sample_start = 1'b1;
        start_edge = cyc + 4;
        start_len = len;
        e0_ref = start_edge;
    endtask

    task automatic run_frame(input int len, input int tm, input int dm, input bit stall, input bit hold);
        bit timed_out;
        dut_beats.delete();
        n_stclr = 0;
        dmode = dm;
        tmode = stall ? 1 : tm;
        start_pulse(len);
        repeat (6) @(posedge clk);
        #1;
        if (!hold) sample_start = 1'b0;
        timed_out = 1;
        for (int i = 0; i < 20000; i++) begin
            if (stall && cyc >= start_edge + len + 2) tmode = tm;
            if (!m_busy && mq.size() == 0 && !m_pend && !m_cap && !m_wv) begin
                timed_out = 0;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("frame_timeout", 64'(timed_out), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        if (hold) begin
            repeat (30) @(posedge clk);
            #1;
            sample_start = 1'b0;
            repeat (5) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_tvalid", 64'(tvalid), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;

        run_frame(8, 0, 1, 0, 0);
        check("len8_nbeats", 64'(dut_beats.size()), 64'd2);
        check("len8_beat0", 64'(dut_beats[0]), 64'({1'b0, 4'hF, 32'h03020100}));
        check("len8_beat1", 64'(dut_beats[1]), 64'({1'b1, 4'hF, 32'h07060504}));
        check("len8_stclr_count", 64'(n_stclr), 64'd1);
        check("len8_overflow", 64'(overflow), 64'd0);

        run_frame(6, 0, 1, 0, 0);
        check("len6_nbeats", 64'(dut_beats.size()), 64'd2);
        check("len6_beat0", 64'(dut_beats[0]), 64'({1'b0, 4'hF, 32'h03020100}));
        check("len6_beat1", 64'(dut_beats[1]), 64'({1'b1, 4'h3, 32'h00000504}));

        run_frame(1, 0, 2, 0, 0);
        check("len1_nbeats", 64'(dut_beats.size()), 64'd1);
        check("len1_beat0", 64'(dut_beats[0]), 64'({1'b1, 4'h1, 24'd0, LEN1_BYTE}));

        run_frame(200, 0, 1, 1, 0);
        check("len200_nbeats", 64'(dut_beats.size()), 64'd17);
        check("len200_beat15", 64'(dut_beats[15]), 64'({1'b0, 4'hF, 32'h3F3E3D3C}));
        check("len200_beat16", 64'(dut_beats[16]), 64'({1'b1, 4'hF, 32'hC7C6C5C4}));
        check("len200_overflow", 64'(overflow), 64'd1);

        run_frame(64, 2, 1, 0, 0);
        check("len64_nbeats", 64'(dut_beats.size()), 64'd16);
        check("len64_beat15", 64'(dut_beats[15]), 64'({1'b1, 4'hF, 32'h3F3E3D3C}));
        check("len64_overflow", 64'(overflow), 64'd0);

        run_frame(0, 0, 1, 0, 0);
        check("len0_stclr_count", 64'(n_stclr), 64'd1);
        check("len0_nbeats", 64'(dut_beats.size()), 64'd0);

        run_frame(8, 0, 1, 0, 1);
        check("hold_stclr_count", 64'(n_stclr), 64'd1);
        check("hold_nbeats", 64'(dut_beats.size()), 64'd2);

        // Reset twenty cycles into a 64-sample capture
        dut_beats.delete();
        dmode = 1;
        tmode = 0;
        start_pulse(64);
        repeat (6) @(posedge clk);
        #1;
        sample_start = 1'b0;
        while (cyc < start_edge + 20) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_tvalid", 64'(tvalid), 64'd0);
        check("midrst_tdata", 64'(tdata), 64'd0);
        check("midrst_stclr", 64'(st_clr), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        begin
            int nl;
            nl = 0;
            foreach (dut_beats[i]) if (dut_beats[i].last) nl++;
            check("midrst_no_tlast", 64'(nl), 64'd0);
        end
        run_frame(8, 0, 1, 0, 0);
        check("post_rst_nbeats", 64'(dut_beats.size()), 64'd2);
        check("post_rst_beat0", 64'(dut_beats[0]), 64'({1'b0, 4'hF, 32'h03020100}));
        check("post_rst_beat1", 64'(dut_beats[1]), 64'({1'b1, 4'hF, 32'h07060504}));

        for (int i = 0; i < 6; i++)
            run_frame($urandom_range(1, 50), 3, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
